// File: rtl/tmu_addresses.sv
`default_nettype none
// ============================================================================
//  Module   : tmu_addresses
//  Purpose  : Two-stage address pipeline for the texture mapping unit.
//             Turns filtered source (U,V) and destination (X,Y) pixel
//             coordinates into linear pixel addresses:
//               src_addr = src_fbuf + V*src_hres + U
//               dst_addr = dst_fbuf + Y*dst_hres + X
//             Stage 1 forms the line products, stage 2 adds the column
//             offset and the framebuffer base.
//  Ports    : sys_clk, sys_rst          clock / synchronous active-high reset
//             busy                      any stage holds a valid entry
//             src_fbuf, dst_fbuf        framebuffer bases (pixel units)
//             src_hres, dst_hres        line widths in pixels
//             pipe_stb_i / pipe_ack_o   upstream handshake
//             P_Xf, P_Yf, P_Uf, P_Vf    filtered coordinates
//             pipe_stb_o / pipe_ack_i   downstream handshake
//             src_addr, dst_addr        computed pixel addresses
//  Revision : 1.0  initial release
// ============================================================================
module tmu_addresses #(
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  output logic                 busy,

  input  logic [fml_depth-2:0] src_fbuf,
  input  logic [fml_depth-2:0] dst_fbuf,
  input  logic [10:0]          src_hres,
  input  logic [10:0]          dst_hres,

  input  logic                 pipe_stb_i,
  output logic                 pipe_ack_o,
  input  logic [10:0]          P_Xf,
  input  logic [10:0]          P_Yf,
  input  logic [10:0]          P_Uf,
  input  logic [10:0]          P_Vf,

  output logic                 pipe_stb_o,
  input  logic                 pipe_ack_i,
  output logic [fml_depth-2:0] src_addr,
  output logic [fml_depth-2:0] dst_addr
);

  // Pixel address width (16-bit pixels, so one bit less than the byte address).
  localparam int AW = fml_depth - 1;

  logic        r_s1_valid;
  logic        r_s2_valid;
  logic [21:0] r_src_prod;
  logic [21:0] r_dst_prod;
  logic [10:0] r_p_uf;
  logic [10:0] r_p_xf;

  logic        w_en;
  logic [21:0] w_src_sum;
  logic [21:0] w_dst_sum;

  // The whole pipeline moves as one: it advances whenever the output slot is
  // empty or is being consumed, which also collapses bubbles.
  assign w_en       = ~r_s2_valid | pipe_ack_i;
  assign pipe_ack_o = w_en;
  assign pipe_stb_o = r_s2_valid;
  assign busy       = r_s1_valid | r_s2_valid;

  // 2047*2047 + 2047 still fits in 22 bits, so the inner sums never overflow.
  assign w_src_sum = r_src_prod + {11'd0, r_p_uf};
  assign w_dst_sum = r_dst_prod + {11'd0, r_p_xf};

  // Valid bits: the only state that needs a reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= pipe_stb_i;
      r_s2_valid <= r_s1_valid;
    end
  end

  // Data path: contents are meaningless while the matching valid bit is low,
  // so these registers are left unreset. The final add wraps modulo 2^AW.
  always_ff @(posedge sys_clk) begin
    if (w_en) begin
      r_src_prod <= 22'(P_Vf) * 22'(src_hres);
      r_dst_prod <= 22'(P_Yf) * 22'(dst_hres);
      r_p_uf     <= P_Uf;
      r_p_xf     <= P_Xf;
      src_addr   <= src_fbuf + AW'(w_src_sum);
      dst_addr   <= dst_fbuf + AW'(w_dst_sum);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmu_addresses.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmu_addresses
//  Purpose  : Self-checking bench for tmu_addresses. A queue-based reference
//             model holds every accepted entry with its expected addresses
//             (computed as base + line*width + column, modulo the address
//             range) and compares them in order at each output transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmu_addresses;

  localparam int          FML_DEPTH = 26;
  localparam int          AW        = FML_DEPTH - 1;
  localparam logic [63:0] MASK      = (64'd1 << AW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic [AW-1:0] src_fbuf = '0;
  logic [AW-1:0] dst_fbuf = '0;
  logic [10:0]   src_hres = '0;
  logic [10:0]   dst_hres = '0;
  logic          stb_i = 1'b0;
  logic          ack_o;
  logic [10:0]   p_x = '0;
  logic [10:0]   p_y = '0;
  logic [10:0]   p_u = '0;
  logic [10:0]   p_v = '0;
  logic          stb_o;
  logic          ack_i = 1'b0;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;

  tmu_addresses #(.fml_depth(FML_DEPTH)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .busy       (busy),
    .src_fbuf   (src_fbuf),
    .dst_fbuf   (dst_fbuf),
    .src_hres   (src_hres),
    .dst_hres   (dst_hres),
    .pipe_stb_i (stb_i),
    .pipe_ack_o (ack_o),
    .P_Xf       (p_x),
    .P_Yf       (p_y),
    .P_Uf       (p_u),
    .P_Vf       (p_v),
    .pipe_stb_o (stb_o),
    .pipe_ack_i (ack_i),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_addr(input logic [63:0] fbuf, input logic [63:0] hres,
                                           input logic [63:0] line, input logic [63:0] col);
    return (fbuf + hres * line + col) & MASK;
  endfunction

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [63:0] src;
    logic [63:0] dst;
    int          acc_cyc;
    bit          stalled;
  } exp_t;

  exp_t          q[$];
  int            out_cyc[$];
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_src;
  logic [AW-1:0] prev_dst;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("ack_o_rule", ack_o, !stb_o || ack_i);
      chk("busy", busy, q.size() != 0);
      if (prev_stall) begin
        chk("hold_stb", stb_o, 1);
        chk("hold_src", src_addr, prev_src);
        chk("hold_dst", dst_addr, prev_dst);
      end
      if (stb_o && !ack_i)
        foreach (q[i]) q[i].stalled = 1'b1;
      if (stb_o && ack_i) begin
        out_cyc.push_back(cyc);
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("src_addr", src_addr, e.src);
          chk("dst_addr", dst_addr, e.dst);
          if (!e.stalled) chk("latency", 64'(cyc - e.acc_cyc), 2);
        end
      end
      if (stb_i && ack_o) begin
        e.src     = ref_addr(src_fbuf, src_hres, p_v, p_u);
        e.dst     = ref_addr(dst_fbuf, dst_hres, p_y, p_x);
        e.acc_cyc = cyc;
        e.stalled = 1'b0;
        q.push_back(e);
      end
      prev_stall = stb_o && !ack_i;
      prev_src   = src_addr;
      prev_dst   = dst_addr;
    end
  end

  // -------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] x, input logic [10:0] y,
                      input logic [10:0] u, input logic [10:0] v);
    bit ok = 1'b0;
    stb_i = 1'b1;
    p_x = x; p_y = y; p_u = u; p_v = v;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = ack_o;
      step();
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    stb_i = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = !busy;
    end
    chk("drain", busy, 0);
    step();
  endtask

  task automatic rand_run(input int ncyc);
    bit acc = 1'b0;
    src_fbuf = AW'($urandom);
    dst_fbuf = AW'($urandom);
    src_hres = ($urandom % 4 == 0) ? 11'd2047 : 11'($urandom_range(1, 2047));
    dst_hres = 11'($urandom_range(1, 2047));
    stb_i = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      if (!stb_i || acc) begin
        stb_i = ($urandom % 10) < 7;
        p_x = ($urandom % 8 == 0) ? 11'd2047 : 11'($urandom);
        p_y = 11'($urandom);
        p_u = ($urandom % 8 == 0) ? 11'd2047 : 11'($urandom);
        p_v = ($urandom % 8 == 0) ? 11'd2047 : 11'($urandom);
      end
      ack_i = ($urandom % 10) < 6;
      @(negedge clk);
      acc = stb_i && ack_o;
      step();
    end
    ack_i = 1'b1;
    drain();
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    int t0;
    int n0;
    bit seen;

    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stb_o", stb_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack_o", ack_o, 1);
    step();

    // Single entry: base 0x1000, width 640, (U,V)=(5,3).
    src_fbuf = 25'h1000; src_hres = 11'd640;
    dst_fbuf = 25'h0;    dst_hres = 11'd100;
    ack_i = 1'b1;
    stb_i = 1'b1; p_u = 11'd5; p_v = 11'd3; p_x = 11'd1; p_y = 11'd1;
    @(negedge clk);
    t0 = cyc;
    step();
    stb_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      seen = stb_o;
    end
    chk("single_seen", seen, 1);
    chk("single_latency", 64'(cyc - t0), 2);
    chk("single_src", src_addr, 25'h1785);
    @(negedge clk);
    chk("single_one_cycle", stb_o, 0);
    drain();

    // Eight back-to-back entries along the diagonal.
    dst_fbuf = '0; dst_hres = 11'd1024;
    n0 = out_cyc.size();
    for (int i = 0; i < 8; i++) send(11'(i), 11'(i), 11'(i), 11'(i));
    drain();
    chk("b2b_count", 64'(out_cyc.size() - n0), 8);
    chk("b2b_no_gaps", 64'(out_cyc[out_cyc.size()-1] - out_cyc[n0]), 7);

    // Four entries with a three-cycle downstream stall in the middle.
    fork
      begin
        for (int i = 0; i < 4; i++) send(11'(10 + i), 11'(20 + i), 11'(30 + i), 11'(40 + i));
        stb_i = 1'b0;
      end
      begin
        step(); step();
        ack_i = 1'b0;
        step(); step(); step();
        ack_i = 1'b1;
      end
    join
    drain();

    // Address wrap at the top of the pixel space.
    src_fbuf = 25'h1FFFFFF;
    send(11'd0, 11'd0, 11'd2, 11'd0);
    stb_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      seen = stb_o;
    end
    chk("wrap_seen", seen, 1);
    chk("wrap_src", src_addr, 25'h0000001);
    drain();

    // Reset with two entries in flight.
    ack_i = 1'b0;
    send(11'd7, 11'd7, 11'd7, 11'd7);
    send(11'd8, 11'd8, 11'd8, 11'd8);
    stb_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stb_o", stb_o, 0);
    chk("midrst_busy", busy, 0);
    ack_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("post_rst_stb_o", stb_o, 0);
    end
    step();

    // Strobe toggled every other cycle; busy must clear two cycles after the last accept.
    for (int i = 0; i < 6; i++) begin
      send(11'(100 + i), 11'(3 * i), 11'(200 + i), 11'(5 * i));
      stb_i = 1'b0;
      if (i < 5) step();
    end
    @(negedge clk);
    chk("tail_busy_1", busy, 1);
    @(negedge clk);
    chk("tail_busy_2", busy, 1);
    chk("tail_stb_2", stb_o, 1);
    @(negedge clk);
    chk("tail_busy_3", busy, 0);
    step();

    // Randomized traffic with random back-pressure.
    for (int r = 0; r < 4; r++) rand_run(300);

    chk("model_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/tmu_addresses.md
TMU_ADDRESSES -- requirements
Module: tmu_addresses

Interface
REQ-001 Parameter: fml_depth, default 26, FML byte-address width; pixel addresses are fml_depth-1 bits wide (16-bit pixels).
REQ-002 sys_clk  in  1  sole clock, all state on rising edge.
REQ-003 sys_rst  in  1  synchronous, active-high reset.
REQ-004 busy  out  1  high while any pipeline stage holds a valid entry.
REQ-005 src_fbuf, dst_fbuf  in  fml_depth-1 each  source/destination framebuffer base, pixel units; static during a run.
REQ-006 src_hres, dst_hres  in  11 each  source/destination line widths in pixels; static during a run.
REQ-007 pipe_stb_i  in  1  upstream (filter stage) data valid.
REQ-008 pipe_ack_o  out  1  this block accepts the upstream entry this cycle.
REQ-009 P_Xf, P_Yf, P_Uf, P_Vf  in  11 each  filtered destination (X,Y) and source (U,V) coordinates.
REQ-010 pipe_stb_o  out  1  output address pair valid.
REQ-011 pipe_ack_i  in  1  downstream accepts output this cycle.
REQ-012 src_addr, dst_addr  out  fml_depth-1 each  computed pixel addresses.

Function
REQ-013 Transfer on input occurs when pipe_stb_i & pipe_ack_o; on output when pipe_stb_o & pipe_ack_i.
REQ-014 Two register stages S1, S2 with valid bits s1_valid, s2_valid; pipe_stb_o = s2_valid.
REQ-015 Pipeline enable en = ~s2_valid | pipe_ack_i; pipe_ack_o = en; all stage registers and valid bits update only when en.
REQ-016 S1 on en: src_prod <= P_Vf*src_hres, dst_prod <= P_Yf*dst_hres (22-bit unsigned each); store P_Uf, P_Xf; s1_valid <= pipe_stb_i.
REQ-017 S2 on en: src_addr <= src_fbuf + zero-extended(src_prod + P_Uf); dst_addr <= dst_fbuf + zero-extended(dst_prod + P_Xf); s2_valid <= s1_valid.
REQ-018 Inner sums 22-bit unsigned, no truncation; final add modulo 2^(fml_depth-1) (wraps, no error flag).
REQ-019 Latency: entry accepted in cycle N appears on outputs in cycle N+2 when downstream never stalls.
REQ-020 Throughput: one entry per cycle while pipe_ack_i high.
REQ-021 Stall: pipe_ack_i low with s2_valid high freezes both stages and holds src_addr/dst_addr/pipe_stb_o stable; pipe_ack_o low.
REQ-022 Bubble collapse: with s2_valid low, pipeline advances regardless of pipe_ack_i.
REQ-023 Simultaneous output and input transfer in one cycle loses and duplicates no entry.
REQ-024 busy = s1_valid | s2_valid.
REQ-025 Data registers with valid low are don't-care; only valid bits qualify outputs.

Reset
REQ-026 On sys_rst: s1_valid, s2_valid <= 0, so pipe_stb_o = 0, busy = 0; pipe_ack_o = 1 from next cycle.
REQ-027 Reset mid-operation discards all in-flight entries; no output transfer after reset asserts.
REQ-028 Data registers need not be reset.

Structure
REQ-029 No shared package; fml_depth is a module parameter only.
REQ-030 Single flat module, no sub-modules; multipliers inferred (11x11), one per address path.

Verification
REQ-031 Reset, then src_fbuf=0x1000, src_hres=640, P_Uf=5, P_Vf=3, ack_i=1 -> src_addr=0x1000+1925=0x1785 two cycles after accept, stb_o one cycle.
REQ-032 dst_fbuf=0, dst_hres=1024, 8 back-to-back entries P_Xf=i, P_Yf=i -> 8 consecutive outputs dst_addr=1025*i, no gaps.
REQ-033 Stream of 4 entries, pipe_ack_i low 3 cycles mid-stream -> outputs held stable, pipe_ack_o low while s2_valid, order preserved, no loss/duplication.
REQ-034 fml_depth=26, src_fbuf=0x1FFFFFF, P_Uf=2, P_Vf=0 -> src_addr=0x0000001 (wrap).
REQ-035 sys_rst pulsed with 2 entries in flight -> pipe_stb_o=0, busy=0 next cycle; no stale output afterwards.
REQ-036 pipe_stb_i toggled every other cycle, ack_i=1 -> outputs follow with 2-cycle latency, busy deasserts 2 cycles after last accept.
